// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - convolution sequencer and MAC engine; optional macro CONV_SATURATE_EN
module conv_sequencer #(
  parameter int DATA_W = 32,
  parameter int AY_W   = 5,
  parameter int AX_W   = 5,
  parameter int AZ_W   = 6
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic              start,
  input  logic [AY_W:0]     size_y,
  input  logic [AX_W:0]     size_x,
  output logic [AY_W-1:0]   y_addr,
  input  logic [DATA_W-1:0] y_data,
  output logic [AX_W-1:0]   x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [AZ_W-1:0]   z_addr,
  output logic [DATA_W-1:0] z_data,
  output logic              z_we,
  output logic              busy,
  output logic              done
);

  localparam int SY_MAX = 1 << AY_W;
  localparam int SX_MAX = 1 << AX_W;
  // wide enough to hold SY+SX without overflow
  localparam int SUM_W  = ((AY_W > AX_W) ? AY_W : AX_W) + 2;

  // S_SKIP is the single bookkeeping cycle an empty run spends before FINISH
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_DRAIN  = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4,
    S_SKIP   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [AY_W:0]     sy_q;
  logic [AX_W:0]     sx_q;
  logic [AZ_W-1:0]   i_q;
  logic [AX_W-1:0]   k_q;
  logic [DATA_W-1:0] acc_q;
  logic              tv_q;
  logic [AX_W-1:0]   x_hold_q;
  logic [AY_W-1:0]   y_hold_q;

  logic [AY_W:0]     sy_in;
  logic [AX_W:0]     sx_in;
  logic              size_zero;
  logic              last_k;
  logic              last_i;
  logic [AZ_W-1:0]   y_idx;
  logic              tv;
  logic              mac_live;
  logic [DATA_W-1:0] acc_sum;

  // oversize requests are clamped to the memory depth
  assign sy_in     = (size_y > (AY_W+1)'(SY_MAX)) ? (AY_W+1)'(SY_MAX) : size_y;
  assign sx_in     = (size_x > (AX_W+1)'(SX_MAX)) ? (AX_W+1)'(SX_MAX) : size_x;
  assign size_zero = (sy_in == '0) || (sx_in == '0);

  assign last_k = ({1'b0, k_q} == (sx_q - (AX_W+1)'(1)));
  assign last_i = (SUM_W'(i_q) == (SUM_W'(sy_q) + SUM_W'(sx_q) - SUM_W'(2)));

  // term i-k exists only when it lands inside the Y buffer
  assign y_idx = i_q - AZ_W'(k_q);
  assign tv    = (i_q >= AZ_W'(k_q)) && (SUM_W'(y_idx) < SUM_W'(sy_q));

  // While stalled, the previous address is re-presented so the memory keeps
  // returning the operands of the still-pending term; nothing is lost on resume.
  assign mac_live = (state_q == S_MAC) && en_s;
  assign x_addr   = mac_live ? k_q : x_hold_q;
  assign y_addr   = mac_live ? AY_W'(y_idx) : y_hold_q;

`ifdef CONV_SATURATE_EN
  logic [2*DATA_W-1:0] prod_full;
  logic [DATA_W-1:0]   prod_sat;
  logic [DATA_W:0]     sum_ext;

  assign prod_full = (2*DATA_W)'(x_data) * (2*DATA_W)'(y_data);
  assign prod_sat  = (|prod_full[2*DATA_W-1:DATA_W]) ? '1 : prod_full[DATA_W-1:0];
  assign sum_ext   = {1'b0, acc_q} + {1'b0, prod_sat};
  assign acc_sum   = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
`else
  logic [DATA_W-1:0] prod_lo;

  assign prod_lo = x_data * y_data;
  assign acc_sum = acc_q + prod_lo;
`endif

  // state register, frozen while en_s is low
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= S_IDLE;
    end else if (en_s) begin
      state_q <= state_d;
    end
  end

  // next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    z_we    = 1'b0;
    z_addr  = i_q;
    z_data  = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = size_zero ? S_SKIP : S_MAC;
        end
      end
      S_MAC: begin
        busy = 1'b1;
        if (last_k) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        z_we    = 1'b1;
        state_d = last_i ? S_FINISH : S_MAC;
      end
      S_SKIP: begin
        busy    = 1'b1;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // counters, term-valid pipeline, accumulator and address hold registers
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      sy_q     <= '0;
      sx_q     <= '0;
      i_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      tv_q     <= 1'b0;
      x_hold_q <= '0;
      y_hold_q <= '0;
    end else if (en_s) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sy_q  <= sy_in;
            sx_q  <= sx_in;
            i_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            tv_q  <= 1'b0;
          end
        end
        S_MAC: begin
          tv_q     <= tv;
          x_hold_q <= k_q;
          y_hold_q <= AY_W'(y_idx);
          if (tv_q) begin
            acc_q <= acc_sum;
          end
          if (!last_k) begin
            k_q <= k_q + AX_W'(1);
          end
        end
        S_DRAIN: begin
          tv_q <= 1'b0;
          if (tv_q) begin
            acc_q <= acc_sum;
          end
        end
        S_WRITE: begin
          acc_q <= '0;
          k_q   <= '0;
          if (!last_i) begin
            i_q <= i_q + AZ_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
